// File: rtl/ports_sfr_ctrl.sv
// SFR-bus controller for the GPIO ports: P0..P4 data latches, P0EN..P3EN direction regs,
// pad readback synchronizers and an optional P0 pin-change interrupt (enabled by PORTS_IRQ_EN).
module ports_sfr_ctrl #(
  parameter int          SYNC_STAGES  = 2,
  parameter logic [7:0]  P0_ADDR      = 8'h80,
  parameter logic [7:0]  P1_ADDR      = 8'h90,
  parameter logic [7:0]  P2_ADDR      = 8'hA0,
  parameter logic [7:0]  P3_ADDR      = 8'hB0,
  parameter logic [7:0]  P4_ADDR      = 8'hC0,
  parameter logic [7:0]  P0EN_ADDR    = 8'h81,
  parameter logic [7:0]  P1EN_ADDR    = 8'h91,
  parameter logic [7:0]  P2EN_ADDR    = 8'hA1,
  parameter logic [7:0]  P3EN_ADDR    = 8'hB1,
  parameter logic [7:0]  IRQ_MSK_ADDR = 8'hC1,
  parameter logic [7:0]  IRQ_FLG_ADDR = 8'hC2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] sfr_addr_i,
  input  logic [7:0] sfr_wdata_i,
  input  logic       sfr_wr_i,
  input  logic       sfr_rd_i,
  input  logic       sfr_rmw_i,
  output logic [7:0] sfr_rdata_o,
  output logic       sfr_ack_o,
  output logic [7:0] ports_sfr_P0EN_o,
  output logic [7:0] ports_sfr_P1EN_o,
  output logic [7:0] ports_sfr_P2EN_o,
  output logic [7:0] ports_sfr_P3EN_o,
  output logic [7:0] ports_sfr_P0_o,
  output logic [7:0] ports_sfr_P1_o,
  output logic [7:0] ports_sfr_P2_o,
  output logic [7:0] ports_sfr_P3_o,
  output logic [7:0] ports_sfr_P4_o,
  input  logic [7:0] ports_sfr_P0_i,
  input  logic [7:0] ports_sfr_P1_i,
  input  logic [7:0] ports_sfr_P2_i,
  input  logic [7:0] ports_sfr_P3_i,
  output logic       port_irq_o
);

  localparam logic [4:0][7:0] PN_ADDR = {P4_ADDR, P3_ADDR, P2_ADDR, P1_ADDR, P0_ADDR};
  localparam logic [3:0][7:0] EN_ADDR = {P3EN_ADDR, P2EN_ADDR, P1EN_ADDR, P0EN_ADDR};

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_ACK} state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_addr, r_wdata;
  logic       r_rmw;
  logic [7:0] r_lat [5];
  logic [7:0] r_en  [4];
  logic [7:0] r_sync [4][SYNC_STAGES];
  logic [7:0] w_pad [4];
  logic [7:0] w_pin [4];
  logic [7:0] w_rd_val;
  logic       w_core_hit, w_irq_hit, w_hit, w_accept;

  assign w_pad[0] = ports_sfr_P0_i;
  assign w_pad[1] = ports_sfr_P1_i;
  assign w_pad[2] = ports_sfr_P2_i;
  assign w_pad[3] = ports_sfr_P3_i;

  // Address decode on the live bus; only used in IDLE to accept a request
  always_comb begin
    w_core_hit = 1'b0;
    for (int n = 0; n < 5; n++)
      if (sfr_addr_i == PN_ADDR[n]) w_core_hit = 1'b1;
    for (int n = 0; n < 4; n++)
      if (sfr_addr_i == EN_ADDR[n]) w_core_hit = 1'b1;
  end

  assign w_irq_hit = (sfr_addr_i == IRQ_MSK_ADDR) || (sfr_addr_i == IRQ_FLG_ADDR);
`ifdef PORTS_IRQ_EN
  assign w_hit = w_core_hit || w_irq_hit;
`else
  // Without the interrupt block its addresses never respond, even if aliased
  assign w_hit = w_core_hit && !w_irq_hit;
`endif

  assign w_accept = (r_state == S_IDLE) && w_hit && (sfr_wr_i || sfr_rd_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_hit && sfr_wr_i)      w_state_nxt = S_WRITE;
        else if (w_hit && sfr_rd_i) w_state_nxt = S_READ;
      end
      S_WRITE: w_state_nxt = S_ACK;
      S_READ:  w_state_nxt = S_ACK;
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign sfr_ack_o = (r_state == S_ACK);

  // Request fields are held internally so the requester may drop them after IDLE
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_rmw   <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= sfr_addr_i;
      r_wdata <= sfr_wdata_i;
      r_rmw   <= sfr_rmw_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int n = 0; n < 5; n++) r_lat[n] <= 8'hFF;
      for (int n = 0; n < 4; n++) r_en[n]  <= 8'h00;
    end else if (r_state == S_WRITE) begin
      for (int n = 0; n < 5; n++)
        if (r_addr == PN_ADDR[n]) r_lat[n] <= r_wdata;
      for (int n = 0; n < 4; n++)
        if (r_addr == EN_ADDR[n]) r_en[n] <= r_wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int n = 0; n < 4; n++)
        for (int s = 0; s < SYNC_STAGES; s++) r_sync[n][s] <= '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        r_sync[n][0] <= w_pad[n];
        for (int s = 1; s < SYNC_STAGES; s++) r_sync[n][s] <= r_sync[n][s-1];
      end
    end
  end

  always_comb
    for (int n = 0; n < 4; n++) w_pin[n] = r_sync[n][SYNC_STAGES-1];

`ifdef PORTS_IRQ_EN
  logic [7:0] r_msk, r_flg, r_pin0_q;
  logic       r_irq;
  logic [7:0] w_fall, w_clr, w_flg_nxt;

  assign w_fall    = r_pin0_q & ~w_pin[0] & r_msk;
  assign w_clr     = (r_state == S_WRITE && r_addr == IRQ_FLG_ADDR) ? r_wdata : 8'h00;
  // Clear first, then OR in new edges so a same-cycle edge survives the W1C
  assign w_flg_nxt = (r_flg & ~w_clr) | w_fall;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_msk    <= 8'h00;
      r_flg    <= 8'h00;
      r_pin0_q <= 8'h00;
      r_irq    <= 1'b0;
    end else begin
      if (r_state == S_WRITE && r_addr == IRQ_MSK_ADDR) r_msk <= r_wdata;
      r_flg    <= w_flg_nxt;
      r_pin0_q <= w_pin[0];
      r_irq    <= |w_flg_nxt;
    end
  end

  assign port_irq_o = r_irq;
`else
  assign port_irq_o = 1'b0;
`endif

  always_comb begin
    w_rd_val = 8'h00;
    for (int n = 0; n < 4; n++) begin
      if (r_addr == PN_ADDR[n]) w_rd_val = r_rmw ? r_lat[n] : w_pin[n];
      if (r_addr == EN_ADDR[n]) w_rd_val = r_en[n];
    end
    if (r_addr == P4_ADDR) w_rd_val = r_lat[4];
`ifdef PORTS_IRQ_EN
    if (r_addr == IRQ_MSK_ADDR) w_rd_val = r_msk;
    if (r_addr == IRQ_FLG_ADDR) w_rd_val = r_flg;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)                  sfr_rdata_o <= 8'h00;
    else if (r_state == S_READ) sfr_rdata_o <= w_rd_val;
  end

  assign ports_sfr_P0_o   = r_lat[0];
  assign ports_sfr_P1_o   = r_lat[1];
  assign ports_sfr_P2_o   = r_lat[2];
  assign ports_sfr_P3_o   = r_lat[3];
  assign ports_sfr_P4_o   = r_lat[4];
  assign ports_sfr_P0EN_o = r_en[0];
  assign ports_sfr_P1EN_o = r_en[1];
  assign ports_sfr_P2EN_o = r_en[2];
  assign ports_sfr_P3EN_o = r_en[3];

endmodule

// File: tb/tb_ports_sfr_ctrl.sv
// Scoreboard bench for ports_sfr_ctrl: expected acks/rdata queued at request, checked on ack.
module tb_ports_sfr_ctrl;
  logic       clk, rst;
  logic [7:0] addr, wdata, rdata;
  logic       wr, rd, rmw, ack, irq;
  logic [7:0] en_o [4];
  logic [7:0] p_o  [5];
  logic [7:0] pad  [4];

  typedef struct { int cyc; logic [7:0] rd; } exp_t;
  exp_t sb[$];

  int         cyc, nchk, nbad;
  logic [7:0] m_lat [5];
  logic [7:0] m_en  [4];
  logic [7:0] m_msk, m_flg, last_rd;

  ports_sfr_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .sfr_addr_i(addr), .sfr_wdata_i(wdata), .sfr_wr_i(wr), .sfr_rd_i(rd), .sfr_rmw_i(rmw),
    .sfr_rdata_o(rdata), .sfr_ack_o(ack),
    .ports_sfr_P0EN_o(en_o[0]), .ports_sfr_P1EN_o(en_o[1]),
    .ports_sfr_P2EN_o(en_o[2]), .ports_sfr_P3EN_o(en_o[3]),
    .ports_sfr_P0_o(p_o[0]), .ports_sfr_P1_o(p_o[1]), .ports_sfr_P2_o(p_o[2]),
    .ports_sfr_P3_o(p_o[3]), .ports_sfr_P4_o(p_o[4]),
    .ports_sfr_P0_i(pad[0]), .ports_sfr_P1_i(pad[1]),
    .ports_sfr_P2_i(pad[2]), .ports_sfr_P3_i(pad[3]),
    .port_irq_o(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic is_hit(input logic [7:0] a);
    case (a)
      8'h80, 8'h90, 8'hA0, 8'hB0, 8'hC0, 8'h81, 8'h91, 8'hA1, 8'hB1: return 1'b1;
`ifdef PORTS_IRQ_EN
      8'hC1, 8'hC2: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] exp_read(input logic [7:0] a, input logic m);
    case (a)
      8'h80: return m ? m_lat[0] : pad[0];
      8'h90: return m ? m_lat[1] : pad[1];
      8'hA0: return m ? m_lat[2] : pad[2];
      8'hB0: return m ? m_lat[3] : pad[3];
      8'hC0: return m_lat[4];
      8'h81: return m_en[0];
      8'h91: return m_en[1];
      8'hA1: return m_en[2];
      8'hB1: return m_en[3];
      8'hC1: return m_msk;
      8'hC2: return m_flg;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_write(input logic [7:0] a, input logic [7:0] d);
    case (a)
      8'h80: m_lat[0] = d;  8'h90: m_lat[1] = d;  8'hA0: m_lat[2] = d;
      8'hB0: m_lat[3] = d;  8'hC0: m_lat[4] = d;
      8'h81: m_en[0] = d;   8'h91: m_en[1] = d;   8'hA1: m_en[2] = d;  8'hB1: m_en[3] = d;
      8'hC1: m_msk = d;     8'hC2: m_flg = m_flg & ~d;
      default: ;
    endcase
  endtask

  task automatic model_reset();
    for (int n = 0; n < 5; n++) m_lat[n] = 8'hFF;
    for (int n = 0; n < 4; n++) m_en[n] = 8'h00;
    m_msk = 8'h00; m_flg = 8'h00; last_rd = 8'h00;
  endtask

  task automatic chk_ports();
    for (int n = 0; n < 5; n++) chk($sformatf("P%0d_o", n), p_o[n], m_lat[n]);
    for (int n = 0; n < 4; n++) chk($sformatf("P%0dEN_o", n), en_o[n], m_en[n]);
  endtask

  // Drives one request for a single cycle and checks port outputs at t+2
  task automatic do_req(input logic [7:0] a, input logic [7:0] d,
                        input logic w, input logic r, input logic m);
    exp_t e;
    @(posedge clk); #1;
    addr = a; wdata = d; wr = w; rd = r; rmw = m;
    if (is_hit(a) && (w || r)) begin
      if (w) model_write(a, d);
      else   last_rd = exp_read(a, m);
      e.cyc = cyc + 2; e.rd = last_rd;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    addr = 8'h00; wdata = 8'h00; wr = 1'b0; rd = 1'b0; rmw = 1'b0;
    @(negedge clk); @(negedge clk);
    chk_ports();
    @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && ack === 1'b1) begin
      if (sb.size() == 0) chk("spurious_ack", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_cyc", cyc, e.cyc);
        chk("rdata", rdata, e.rd);
      end
    end
  end

  initial begin
    logic [7:0] alist [9];
    alist = '{8'h80, 8'h90, 8'hA0, 8'hB0, 8'hC0, 8'h81, 8'h91, 8'hA1, 8'hB1};
    nchk = 0; nbad = 0; cyc = 0;
    rst = 1'b1; addr = 0; wdata = 0; wr = 0; rd = 0; rmw = 0;
    pad[0] = 8'hA5; pad[1] = 8'h11; pad[2] = 8'h00; pad[3] = 8'h99;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_ports();
    chk("rst_ack", ack, 0);
    chk("rst_irq", irq, 0);
    chk("rst_rdata", rdata, 0);

    do_req(8'h90, 8'h5A, 1, 0, 0);
    do_req(8'h91, 8'h00, 0, 1, 0);
    do_req(8'h81, 8'hF0, 1, 0, 0);
    do_req(8'h81, 8'h00, 0, 1, 0);

    pad[2] = 8'h3C;
    repeat (3) @(posedge clk);
    do_req(8'hA0, 8'h00, 0, 1, 0);
    do_req(8'hA0, 8'h00, 0, 1, 1);

    do_req(8'hC0, 8'h00, 0, 1, 0);
    do_req(8'hC0, 8'h12, 1, 0, 0);
    do_req(8'hC0, 8'h00, 0, 1, 0);
    do_req(8'hB0, 8'h77, 1, 1, 0);   // write wins, rdata must keep 8'h12
    do_req(8'h55, 8'hEE, 1, 1, 0);
    do_req(8'hC1, 8'h00, 0, 1, 0);   // no ack unless the IRQ block exists

`ifdef PORTS_IRQ_EN
    do_req(8'hC1, 8'h01, 1, 0, 0);
    pad[0][0] = 1'b0;
    repeat (4) @(posedge clk);
    m_flg = 8'h01;
    @(negedge clk); chk("irq_set", irq, 1);
    do_req(8'hC2, 8'h00, 0, 1, 0);
    do_req(8'hC2, 8'h01, 1, 0, 0);
    chk("irq_clr", irq, 0);
    pad[0][0] = 1'b1;
    repeat (4) @(posedge clk);
    @(posedge clk); #1 pad[0][0] = 1'b0;   // falling edge lands in the clearing WRITE cycle
    do_req(8'hC2, 8'h01, 1, 0, 0);
    m_flg = 8'h01;
    chk("irq_collide", irq, 1);
    do_req(8'hC2, 8'h00, 0, 1, 0);
`endif

    // reset while the FSM sits in READ
    @(posedge clk); #1 addr = 8'h80; rd = 1'b1;
    @(posedge clk); #1 addr = 8'h00; rd = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("midrst_ack", ack, 0);
    chk("midrst_rdata", rdata, 0);
    chk("midrst_irq", irq, 0);
    repeat (3) @(negedge clk);
    chk_ports();
    do_req(8'h80, 8'h00, 0, 1, 0);

    for (int i = 0; i < 24; i++) begin
      logic [7:0] a;
      logic       w;
      a = alist[$urandom_range(0, 8)];
      w = 1'($urandom_range(0, 1));
      do_req(a, 8'($urandom), w, !w, 1'($urandom_range(0, 1)));
    end

    repeat (4) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nbad);
    $finish;
  end
endmodule
